// File: rtl/wb_boot_loader.sv
// wb_boot_loader: Wishbone boot master streaming an image into core memory with optional readback; ports: image stream in (img_*), Wishbone master (wbm_*), core reset and load status out
module wb_boot_loader #(
  parameter int NUM_WORDS = 10,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int VERIFY = 1,
  parameter int TIMEOUT = 255,
  localparam int SEL_W = DATA_W / 8,
  localparam int IDX_W = $clog2(NUM_WORDS + 1)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic              img_valid_i,
  input  logic [DATA_W-1:0] img_data_i,
  output logic              img_ready_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  input  logic [DATA_W-1:0] wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  output logic              core_rst_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [IDX_W-1:0]  err_idx_o
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, READ, NEXT, DONE, ERROR} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, err_idx_q, err_idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0] code_q, code_d;
  logic cyc_q, cyc_d, we_q, we_d, rdy_q, rdy_d, core_rst_q, core_rst_d, done_q, done_d, err_q, err_d;
  logic go, hs, tmo_hit, last;
  assign go = start_i && (state_q == IDLE || state_q == DONE || state_q == ERROR);
  assign hs = img_valid_i && rdy_q;
  assign tmo_hit = tmo_q == TMO_W'(TIMEOUT - 1);
  assign last = idx_q + IDX_W'(1) == IDX_W'(NUM_WORDS);
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      idx_q <= '0;
      err_idx_q <= '0;
      word_q <= '0;
      adr_q <= '0;
      tmo_q <= '0;
      code_q <= '0;
      cyc_q <= 1'b0;
      we_q <= 1'b0;
      rdy_q <= 1'b0;
      core_rst_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      err_idx_q <= err_idx_d;
      word_q <= word_d;
      adr_q <= adr_d;
      tmo_q <= tmo_d;
      code_q <= code_d;
      cyc_q <= cyc_d;
      we_q <= we_d;
      rdy_q <= rdy_d;
      core_rst_q <= core_rst_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: state_d = go ? FETCH : state_q;
      FETCH: state_d = hs ? WRITE : FETCH;
      WRITE: state_d = wbm_err_i || (!wbm_ack_i && tmo_hit) ? ERROR :
                       wbm_ack_i ? (VERIFY != 0 ? READ : NEXT) : WRITE;
      READ:  state_d = wbm_err_i || (!wbm_ack_i && tmo_hit) || (wbm_ack_i && wbm_dat_i != word_q) ? ERROR :
                       wbm_ack_i ? NEXT : READ;
      NEXT:  state_d = last ? DONE : FETCH;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rdy_d = state_d == FETCH;
    cyc_d = state_d == WRITE || state_d == READ;
    we_d = state_d == WRITE;
    core_rst_d = state_d != DONE;
    done_d = state_d == DONE;
    err_d = state_d == ERROR;
    idx_d = go ? '0 : state_q == NEXT ? idx_q + IDX_W'(1) : idx_q;
    word_d = hs ? img_data_i : word_q;
    adr_d = hs ? BASE_ADDR + ADDR_W'(idx_q) * ADDR_W'(SEL_W) : adr_q;
    tmo_d = cyc_d && state_d == state_q ? tmo_q + TMO_W'(1) : '0;
    code_d = go ? 2'd0 : err_d && !err_q ? (wbm_err_i ? 2'd1 : wbm_ack_i ? 2'd3 : 2'd2) : code_q;
    err_idx_d = err_d && !err_q ? idx_q : err_idx_q;
  end
  assign img_ready_o = rdy_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o = we_q;
  assign wbm_sel_o = {SEL_W{cyc_q}};
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = word_q;
  assign core_rst_o = core_rst_q;
  assign done_o = done_q;
  assign err_o = err_q;
  assign err_code_o = code_q;
  assign err_idx_o = err_idx_q;
endmodule
